// File: rtl/alu_4bit_seq.sv
// rtl/alu_4bit_seq.sv - sequential wide-operand initiator for an external combinational 4-bit ALU
module alu_4bit_seq #(
   parameter  int NIBBLES = 2,
   localparam int W       = 4 * NIBBLES
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         REQ_VALID,
   output logic         REQ_READY,
   input  logic [2:0]   REQ_OP,
   input  logic [W-1:0] REQ_A,
   input  logic [W-1:0] REQ_B,
   output logic [2:0]   ALU_SEL,
   output logic [3:0]   ALU_A,
   output logic [3:0]   ALU_B,
   input  logic [4:0]   ALU_O,
   input  logic         ALU_CARRY,
   output logic         RSP_VALID,
   input  logic         RSP_READY,
   output logic [W-1:0] RSP_RESULT,
   output logic         RSP_CARRY
);

   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PASS,
      ST_FIX,
      ST_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   r_q, r_d;
   logic [2:0]     op_q, op_d;
   logic [1:0]     idx_q, idx_d;
   logic           cin_q, cin_d;
   logic           c1_q, c1_d;

   logic [3:0]     a_nib;
   logic [3:0]     b_nib;
   logic [3:0]     r_nib;
   logic [W-1:0]   r_wr;
   logic           is_arith;
   logic           last_nib;
   logic           advance;
   logic           c1_now;

   // ALU_O[4] is not part of the contract; the carry comes from ALU_CARRY
   logic           unused_alu_msb;
   assign unused_alu_msb = ALU_O[4];

   // Select the current nibble of each operand and build R with the current nibble replaced
   always_comb begin
      a_nib    = '0;
      b_nib    = '0;
      r_nib    = '0;
      r_wr     = r_q;
      for (int n = 0; n < NIBBLES; n++) begin
         if (idx_q == 2'(n)) begin
            a_nib           = a_q[4*n +: 4];
            b_nib           = b_q[4*n +: 4];
            r_nib           = r_q[4*n +: 4];
            r_wr[4*n +: 4]  = ALU_O[3:0];
         end
      end
      is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
      last_nib = (idx_q == 2'(NIBBLES - 1));
   end

   // Next-state and output logic of the nibble sequencer
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      r_d       = r_q;
      op_d      = op_q;
      idx_d     = idx_q;
      cin_d     = cin_q;
      c1_d      = c1_q;
      REQ_READY = 1'b0;
      RSP_VALID = 1'b0;
      ALU_SEL   = 3'b000;
      ALU_A     = 4'h0;
      ALU_B     = 4'h0;
      advance   = 1'b0;
      c1_now    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            REQ_READY = 1'b1;
            if (REQ_VALID) begin
               a_d     = REQ_A;
               b_d     = REQ_B;
               op_d    = REQ_OP[2] ? OP_SUB : REQ_OP;
               r_d     = '0;
               idx_d   = 2'd0;
               cin_d   = 1'b0;
               c1_d    = 1'b0;
               state_d = ST_PASS;
            end
         end

         ST_PASS: begin
            ALU_SEL = op_q;
            ALU_A   = a_nib;
            ALU_B   = b_nib;
            r_d     = r_wr;
            c1_now  = is_arith & ALU_CARRY;
            c1_d    = c1_now;
            // The ALU has no carry-in, so a pending carry/borrow costs an extra +/-1 pass
            if (is_arith && cin_q) begin
               state_d = ST_FIX;
            end else begin
               cin_d   = c1_now;
               advance = 1'b1;
            end
         end

         ST_FIX: begin
            ALU_SEL = op_q;
            ALU_A   = r_nib;
            ALU_B   = 4'h1;
            r_d     = r_wr;
            // A nibble op and its +/-1 correction can never both carry
            cin_d   = c1_q | ALU_CARRY;
            advance = 1'b1;
         end

         ST_DONE: begin
            RSP_VALID = 1'b1;
            if (RSP_READY) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (advance) begin
         if (last_nib) begin
            state_d = ST_DONE;
         end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_PASS;
         end
      end
   end

   // Response data is only presented while the response is valid
   always_comb begin
      RSP_RESULT = (state_q == ST_DONE) ? r_q : '0;
      RSP_CARRY  = (state_q == ST_DONE) ? cin_q : 1'b0;
   end

   // State and datapath registers; reset discards any operation in flight
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         op_q    <= 3'b000;
         idx_q   <= 2'd0;
         cin_q   <= 1'b0;
         c1_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         cin_q   <= cin_d;
         c1_q    <= c1_d;
      end
   end

endmodule

// File: tb/tb_alu_4bit_seq.sv
// tb/tb_alu_4bit_seq.sv - self-checking bench for alu_4bit_seq with an ALU model and reference scoreboard
module tb_alu_4bit_seq;

   localparam int NIBBLES = 2;
   localparam int W       = 4 * NIBBLES;

   localparam int M_IDLE = 0;
   localparam int M_BUSY = 1;
   localparam int M_DONE = 2;

   logic         CLK;
   logic         RST_N;
   logic         REQ_VALID;
   logic         REQ_READY;
   logic [2:0]   REQ_OP;
   logic [W-1:0] REQ_A;
   logic [W-1:0] REQ_B;
   logic [2:0]   ALU_SEL;
   logic [3:0]   ALU_A;
   logic [3:0]   ALU_B;
   logic [4:0]   ALU_O;
   logic         ALU_CARRY;
   logic         RSP_VALID;
   logic         RSP_READY;
   logic [W-1:0] RSP_RESULT;
   logic         RSP_CARRY;

   int           n_checks = 0;
   int           n_fail   = 0;
   int           n_rsp    = 0;

   int           m_state;
   int           m_cnt;
   logic [W-1:0] m_r;
   logic         m_c;
   logic [W-1:0] t_r;
   logic         t_c;
   int           t_l;

   logic [10:0]  alu_log [0:15];

   alu_4bit_seq #(.NIBBLES(NIBBLES)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .REQ_VALID  (REQ_VALID),
      .REQ_READY  (REQ_READY),
      .REQ_OP     (REQ_OP),
      .REQ_A      (REQ_A),
      .REQ_B      (REQ_B),
      .ALU_SEL    (ALU_SEL),
      .ALU_A      (ALU_A),
      .ALU_B      (ALU_B),
      .ALU_O      (ALU_O),
      .ALU_CARRY  (ALU_CARRY),
      .RSP_VALID  (RSP_VALID),
      .RSP_READY  (RSP_READY),
      .RSP_RESULT (RSP_RESULT),
      .RSP_CARRY  (RSP_CARRY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // External combinational 4-bit ALU
   always_comb begin
      ALU_O     = 5'h00;
      ALU_CARRY = 1'b0;
      case (ALU_SEL)
         3'b000: ALU_O = {1'b0, ALU_A & ALU_B};
         3'b001: ALU_O = {1'b0, ALU_A | ALU_B};
         3'b010: ALU_O = {1'b0, ALU_A ^ ALU_B};
         3'b011: begin
            ALU_O     = {1'b0, ALU_A} + {1'b0, ALU_B};
            ALU_CARRY = ALU_O[4];
         end
         default: begin
            ALU_O     = {1'b0, ALU_A} - {1'b0, ALU_B};
            ALU_CARRY = (ALU_A < ALU_B);
         end
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   // Whole-word reference: result, carry/borrow and latency from plain arithmetic
   function automatic void ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic c, output int lat);
      longint ua = longint'(a);
      longint ub = longint'(b);
      longint m;
      lat = NIBBLES;
      c   = 1'b0;
      case (op)
         3'b000: r = a & b;
         3'b001: r = a | b;
         3'b010: r = a ^ b;
         3'b011: begin
            r = W'(ua + ub);
            c = (ua + ub) >= (longint'(1) << W);
            for (int i = 1; i < NIBBLES; i++) begin
               m = longint'(1) << (4 * i);
               if ((ua % m) + (ub % m) >= m) lat++;
            end
         end
         default: begin
            r = W'(ua - ub);
            c = (ua < ub);
            for (int i = 1; i < NIBBLES; i++) begin
               m = longint'(1) << (4 * i);
               if ((ua % m) < (ub % m)) lat++;
            end
         end
      endcase
   endfunction

   // Transaction-level model of the request/response timing
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_state <= M_IDLE;
         m_cnt   <= 0;
         m_r     <= '0;
         m_c     <= 1'b0;
      end else begin
         case (m_state)
            M_IDLE: begin
               if (REQ_VALID) begin
                  ref_op(REQ_OP, REQ_A, REQ_B, t_r, t_c, t_l);
                  m_r     <= t_r;
                  m_c     <= t_c;
                  m_cnt   <= t_l - 1;
                  m_state <= M_BUSY;
               end
            end
            M_BUSY: begin
               if (m_cnt == 0) m_state <= M_DONE;
               else            m_cnt   <= m_cnt - 1;
            end
            default: begin
               if (RSP_READY) begin
                  m_state <= M_IDLE;
                  n_rsp   <= n_rsp + 1;
               end
            end
         endcase
      end
   end

   // Compare DUT outputs against the model on every falling edge
   always @(negedge CLK) begin
      chk("req_ready", 32'(REQ_READY), 32'(m_state == M_IDLE));
      chk("rsp_valid", 32'(RSP_VALID), 32'(m_state == M_DONE));
      if (m_state == M_DONE) begin
         chk("rsp_result", 32'(RSP_RESULT), 32'(m_r));
         chk("rsp_carry", 32'(RSP_CARRY), 32'(m_c));
      end
      if (m_state != M_BUSY) begin
         chk("alu_quiet", 32'({ALU_SEL, ALU_A, ALU_B}), 32'h0);
      end
   end

   // Present a request and return just after the edge that accepts it
   task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit rsp_rdy);
      bit acc = 1'b0;
      @(posedge CLK);
      #2;
      REQ_VALID = 1'b1;
      REQ_OP    = op;
      REQ_A     = a;
      REQ_B     = b;
      RSP_READY = rsp_rdy;
      for (int k = 0; k < 64; k++) begin
         @(negedge CLK);
         if (REQ_READY) begin
            acc = 1'b1;
            break;
         end
      end
      if (!acc) chk("accept_timeout", 32'(0), 32'(1));
      @(posedge CLK);
      #2;
      REQ_VALID = 1'b0;
   endtask

   task automatic run_op(input string nm, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic ec, input int el, input bit hold);
      int lat = -1;
      send(op, a, b, !hold);
      for (int k = 0; k < 64; k++) begin
         @(negedge CLK);
         if (k < 16) alu_log[k] = {ALU_SEL, ALU_A, ALU_B};
         if (RSP_VALID) begin
            lat = k;
            break;
         end
      end
      chk({nm, "_lat"}, 32'(lat), 32'(el));
      chk({nm, "_result"}, 32'(RSP_RESULT), 32'(er));
      chk({nm, "_carry"}, 32'(RSP_CARRY), 32'(ec));
      if (hold) begin
         repeat (5) begin
            @(negedge CLK);
            chk("bp_valid", 32'(RSP_VALID), 32'(1));
            chk("bp_result", 32'(RSP_RESULT), 32'(er));
            chk("bp_req_ready", 32'(REQ_READY), 32'(0));
         end
         @(posedge CLK);
         #2;
         RSP_READY = 1'b1;
         @(posedge CLK);
         @(negedge CLK);
         chk("bp_release_ready", 32'(REQ_READY), 32'(1));
      end
   endtask

   initial begin
      RST_N     = 1'b0;
      REQ_VALID = 1'b0;
      REQ_OP    = 3'b000;
      REQ_A     = '0;
      REQ_B     = '0;
      RSP_READY = 1'b1;
      repeat (2) @(negedge CLK);
      chk("rst_req_ready", 32'(REQ_READY), 32'(1));
      chk("rst_rsp_valid", 32'(RSP_VALID), 32'(0));
      chk("rst_rsp_result", 32'(RSP_RESULT), 32'(0));
      chk("rst_rsp_carry", 32'(RSP_CARRY), 32'(0));
      chk("rst_alu", 32'({ALU_SEL, ALU_A, ALU_B}), 32'(0));
      @(posedge CLK);
      #2;
      RST_N = 1'b1;

      run_op("and", 3'b000, 8'h3C, 8'h5A, 8'h18, 1'b0, 2, 1'b0);
      chk("and_pass0_alu", 32'(alu_log[0]), 32'({3'b000, 4'hC, 4'hA}));
      chk("and_pass1_alu", 32'(alu_log[1]), 32'({3'b000, 4'h3, 4'h5}));
      run_op("add_8f_01", 3'b011, 8'h8F, 8'h01, 8'h90, 1'b0, 3, 1'b0);
      chk("add_fix_alu", 32'(alu_log[2]), 32'({3'b011, 4'h8, 4'h1}));
      run_op("add_ff_01", 3'b011, 8'hFF, 8'h01, 8'h00, 1'b1, 3, 1'b0);
      run_op("add_12_34", 3'b011, 8'h12, 8'h34, 8'h46, 1'b0, 2, 1'b0);
      run_op("sub_10_01", 3'b100, 8'h10, 8'h01, 8'h0F, 1'b0, 3, 1'b0);
      chk("sub_fix_alu", 32'(alu_log[2]), 32'({3'b100, 4'h1, 4'h1}));
      run_op("sub_00_01", 3'b110, 8'h00, 8'h01, 8'hFF, 1'b1, 3, 1'b0);
      chk("sub_norm_sel", 32'(alu_log[0]), 32'({3'b100, 4'h0, 4'h1}));
      run_op("sub_55_55", 3'b111, 8'h55, 8'h55, 8'h00, 1'b0, 2, 1'b0);

      run_op("or_bp", 3'b001, 8'h0A, 8'h50, 8'h5A, 1'b0, 2, 1'b1);
      run_op("b2b_add", 3'b011, 8'h12, 8'h34, 8'h46, 1'b0, 2, 1'b0);
      run_op("b2b_sub", 3'b101, 8'h55, 8'h55, 8'h00, 1'b0, 2, 1'b0);

      send(3'b011, 8'hFF, 8'h01, 1'b1);
      @(negedge CLK);
      #1;
      RST_N = 1'b0;
      #1;
      chk("arst_req_ready", 32'(REQ_READY), 32'(1));
      chk("arst_rsp_valid", 32'(RSP_VALID), 32'(0));
      chk("arst_rsp_result", 32'(RSP_RESULT), 32'(0));
      chk("arst_rsp_carry", 32'(RSP_CARRY), 32'(0));
      chk("arst_alu", 32'({ALU_SEL, ALU_A, ALU_B}), 32'(0));
      repeat (3) @(negedge CLK);
      @(posedge CLK);
      #2;
      RST_N = 1'b1;
      repeat (4) begin
         @(negedge CLK);
         chk("arst_no_rsp", 32'(RSP_VALID), 32'(0));
      end
      chk("arst_ready_after", 32'(REQ_READY), 32'(1));
      run_op("xor_after_rst", 3'b010, 8'hF0, 8'hFF, 8'h0F, 1'b0, 2, 1'b0);

      n_rsp = 0;
      for (int c = 0; c < 1500; c++) begin
         @(posedge CLK);
         #2;
         REQ_VALID = ($urandom_range(0, 2) != 0);
         REQ_OP    = 3'($urandom);
         REQ_A     = ($urandom_range(0, 3) == 0) ? '1 : W'($urandom);
         REQ_B     = ($urandom_range(0, 3) == 0) ? W'(1) : W'($urandom);
         RSP_READY = ($urandom_range(0, 3) != 0);
      end
      @(posedge CLK);
      #2;
      REQ_VALID = 1'b0;
      RSP_READY = 1'b1;
      repeat (10) @(posedge CLK);
      chk("random_responses_seen", 32'(n_rsp > 50), 32'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_4bit_seq.md
Name: alu_4bit_seq

Overview:
- Multi-cycle initiator that drives the team's combinational 4-bit ALU, which sits outside this block and connects via the ALU_* ports.
- Accepts wide operations (NIBBLES×4 bits) on a valid/ready request channel and executes them nibble by nibble, LSB first.
- Inserts a carry/borrow correction pass where the ALU has no carry-in.
- Returns the full-width result plus carry/borrow on a valid/ready response channel.

Parameters:
- NIBBLES, 2, operand width in 4-bit nibbles (legal 1..4); W = 4*NIBBLES.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- REQ_VALID  in  1  request valid
- REQ_READY  out  1  request ready (high only in IDLE)
- REQ_OP  in  3  000 AND, 001 OR, 010 XOR, 011 ADD, 1xx SUB (A-B)
- REQ_A  in  W  operand A
- REQ_B  in  W  operand B
- ALU_SEL  out  3  to ALU SEL
- ALU_A  out  4  to ALU A
- ALU_B  out  4  to ALU B
- ALU_O  in  5  from ALU; only [3:0] used, [4] ignored
- ALU_CARRY  in  1  from ALU; carry for 011, borrow (A<B) for 1xx, 0 otherwise
- RSP_VALID  out  1  response valid
- RSP_READY  in  1  response ready
- RSP_RESULT  out  W  result
- RSP_CARRY  out  1  final carry (ADD) / borrow (SUB); 0 for logic ops

Behaviour:
- Reset (async, any state): state IDLE, REQ_READY=1, RSP_VALID=0, RSP_RESULT=0, RSP_CARRY=0, ALU_SEL=000, ALU_A=0, ALU_B=0. All internal registers cleared; an in-flight operation is discarded with no response.
- ALU_SEL/ALU_A/ALU_B come from registers and state only. The ALU is combinational, so ALU_O/ALU_CARRY are sampled at the end of the same cycle.
- Handshakes:
  - Request accepted on an edge with REQ_VALID & REQ_READY. A, B and OP are captured; REQ_OP 1xx is normalised to 100.
  - Response completes on an edge with RSP_VALID & RSP_READY.
  - RSP_RESULT and RSP_CARRY are stable while RSP_VALID=1.
- FSM IDLE -> PASS -> [FIX] -> ... -> DONE -> IDLE. Index i counts nibbles 0..NIBBLES-1; cin holds the carry/borrow out of nibble i-1 (0 for i=0).
  - IDLE: REQ_READY=1. On accept: i=0, cin=0, go PASS.
  - PASS: ALU_SEL=op, ALU_A=A[i], ALU_B=B[i]. Capture R[i]=ALU_O[3:0] and c1=ALU_CARRY (forced 0 for logic ops).
    - If op is ADD/SUB and cin=1: go FIX.
    - Else: cin=c1; if i=NIBBLES-1 go DONE, else i++ and stay PASS.
  - FIX: ALU_SEL=011 (ADD) or 100 (SUB), ALU_A=R[i], ALU_B=4'h1. Capture R[i]=ALU_O[3:0]. Set cin = c1 | ALU_CARRY (both can never be 1). Then advance exactly as the PASS exit.
  - DONE: RSP_VALID=1, RSP_RESULT=R, RSP_CARRY=cin. On RSP_READY go IDLE.
    - REQ_READY=0 in DONE, so there is no same-cycle accept. The next accept is possible one cycle after the response handshake.
- ALU outputs return to SEL=000, A=B=0 in IDLE and DONE.
- Latency, from the accept edge to the first edge with RSP_VALID=1:
  - Logic ops: exactly NIBBLES cycles.
  - ADD/SUB: NIBBLES plus one cycle per nibble i≥1 entered with cin=1, so at most 2*NIBBLES-1.
- Arithmetic is modulo 2^W. The ADD carry-out is set iff A+B ≥ 2^W. The SUB borrow is set iff A < B (unsigned).
- RSP_READY held low: stay in DONE indefinitely, outputs frozen. REQ_VALID is ignored outside IDLE.

Test Plan:
- NIBBLES=2, AND 0x3C,0x5A -> RSP_RESULT=0x18, RSP_CARRY=0, RSP_VALID high 2 cycles after accept; ALU_SEL=000 on both passes.
- ADD 0x8F+0x01 -> nibble0 carries, FIX pass drives ALU_A=0x8, ALU_B=0x1; RSP_RESULT=0x90, RSP_CARRY=0, latency 3.
- ADD 0xFF+0x01 -> RSP_RESULT=0x00, RSP_CARRY=1, latency 3; also ADD 0x12+0x34 -> 0x46, carry 0, latency 2.
- SUB 0x10-0x01 -> 0x0F, borrow 0, latency 3; SUB 0x00-0x01 -> 0xFF, borrow 1, latency 3; SUB 0x55-0x55 -> 0x00, borrow 0, latency 2.
- Backpressure: hold RSP_READY=0 for 5 cycles after a response is presented -> RSP_VALID/RESULT stay stable and REQ_READY stays 0; release -> REQ_READY=1 the next cycle; back-to-back requests then complete in order.
- Pull RST_N low mid-PASS of an ADD -> outputs go to reset values immediately and no response is issued; after release, REQ_READY=1 and a fresh XOR 0xF0^0xFF returns 0x0F.
